// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with oversampled, majority-voted bit recovery.
// The frame format and baud divider are captured at the start edge and held for the whole frame.
module uart_rx_cfg #(
    parameter int unsigned OVS   = 16,
    parameter int unsigned DIV_W = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [DIV_W-1:0] Baud_Div,
    input  logic [1:0]       Data_Bits,
    input  logic [1:0]       Parity_Mode,
    input  logic             Stop2,
    input  logic             Rs232_Rx,
    output logic [7:0]       Rx_Byte,
    output logic             Rx_Done,
    output logic             Parity_Err,
    output logic             Frame_Err,
    output logic             Busy
);

    localparam int unsigned TW = $clog2(OVS);

    localparam logic [TW-1:0] SampA    = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] SampB    = TW'(OVS / 2);
    localparam logic [TW-1:0] SampC    = TW'(OVS / 2 + 1);
    localparam logic [TW-1:0] TickLast = TW'(OVS - 1);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StStart    = 3'd1;
    localparam logic [2:0] StData     = 3'd2;
    localparam logic [2:0] StParity   = 3'd3;
    localparam logic [2:0] StStop     = 3'd4;
    localparam logic [2:0] StWaitHigh = 3'd5;

    // Synchroniser and edge detection
    logic [1:0]       sync_q;
    logic             rx_s;
    logic             rx_prev_q;
    logic [2:0]       sync_vld_q;

    // Frame state
    logic [2:0]       state_q, state_d;
    logic [DIV_W-1:0] baud_q, baud_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]       data_bits_q, data_bits_d;
    logic [1:0]       par_mode_q, par_mode_d;
    logic             stop2_q, stop2_d;
    logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
    logic             samp_a_q, samp_a_d;
    logic             samp_b_q, samp_b_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic             stop_idx_q, stop_idx_d;
    logic [7:0]       data_q, data_d;
    logic             par_acc_q, par_acc_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;

    // Registered outputs
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic             done_q, done_d;
    logic             parity_err_q, parity_err_d;
    logic             frame_err_q, frame_err_d;

    // Decode helpers
    logic             active;
    logic             tick;
    logic             start_det;
    logic             maj_evt;
    logic             end_evt;
    logic             maj;
    logic             last_data;
    logic             par_en;
    logic             final_stop;

    assign rx_s = sync_q[1];

    // sync_vld_q marks when rx_prev_q holds a genuine line sample rather than a reset value,
    // so a line held low through reset release is never mistaken for a start edge.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sync_q     <= 2'b11;
            rx_prev_q  <= 1'b1;
            sync_vld_q <= 3'b000;
        end else begin
            sync_q     <= {sync_q[0], Rs232_Rx};
            rx_prev_q  <= rx_s;
            sync_vld_q <= {sync_vld_q[1:0], 1'b1};
        end
    end

    assign active     = (state_q == StStart) || (state_q == StData) ||
                        (state_q == StParity) || (state_q == StStop);
    assign tick       = active && (div_cnt_q == baud_q);
    assign start_det  = (state_q == StIdle) && sync_vld_q[2] && rx_prev_q && !rx_s;
    assign maj_evt    = tick && (tick_cnt_q == SampC);
    assign end_evt    = tick && (tick_cnt_q == TickLast);
    assign maj        = (samp_a_q & samp_b_q) | (samp_a_q & rx_s) | (samp_b_q & rx_s);
    assign last_data  = (bit_idx_q == {1'b1, data_bits_q});
    assign par_en     = (par_mode_q == 2'b01) || (par_mode_q == 2'b10);
    assign final_stop = !stop2_q || stop_idx_q;

    always_comb begin
        state_d      = state_q;
        baud_d       = baud_q;
        div_cnt_d    = div_cnt_q;
        data_bits_d  = data_bits_q;
        par_mode_d   = par_mode_q;
        stop2_d      = stop2_q;
        tick_cnt_d   = tick_cnt_q;
        samp_a_d     = samp_a_q;
        samp_b_d     = samp_b_q;
        bit_idx_d    = bit_idx_q;
        stop_idx_d   = stop_idx_q;
        data_d       = data_q;
        par_acc_d    = par_acc_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        rx_byte_d    = rx_byte_q;
        done_d       = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;

        if (tick) begin
            div_cnt_d  = '0;
            tick_cnt_d = (tick_cnt_q == TickLast) ? '0 : tick_cnt_q + TW'(1);
        end else if (active) begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end

        if (tick && (tick_cnt_q == SampA)) begin
            samp_a_d = rx_s;
        end
        if (tick && (tick_cnt_q == SampB)) begin
            samp_b_d = rx_s;
        end

        case (state_q)
            StIdle: begin
                if (start_det) begin
                    baud_d      = Baud_Div;
                    data_bits_d = Data_Bits;
                    par_mode_d  = Parity_Mode;
                    stop2_d     = Stop2;
                    div_cnt_d   = '0;
                    tick_cnt_d  = '0;
                    bit_idx_d   = '0;
                    stop_idx_d  = 1'b0;
                    data_d      = '0;
                    par_acc_d   = 1'b0;
                    perr_d      = 1'b0;
                    ferr_d      = 1'b0;
                    state_d     = StStart;
                end
            end
            StStart: begin
                if (maj_evt && maj) begin
                    state_d = StIdle;
                end else if (end_evt) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (maj_evt) begin
                    data_d[bit_idx_q] = maj;
                    par_acc_d         = par_acc_q ^ maj;
                end
                if (end_evt) begin
                    if (last_data) begin
                        state_d = par_en ? StParity : StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            StParity: begin
                // Odd mode expects the overall XOR to be 1, even mode expects 0.
                if (maj_evt) begin
                    perr_d = par_acc_q ^ maj ^ (par_mode_q == 2'b01);
                end
                if (end_evt) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (maj_evt) begin
                    if (!maj) begin
                        ferr_d = 1'b1;
                    end
                    if (final_stop) begin
                        done_d       = 1'b1;
                        rx_byte_d    = data_q;
                        parity_err_d = perr_q;
                        frame_err_d  = ferr_q | !maj;
                        // Leaving mid-bit lets a start edge in the second half of the stop bit count.
                        state_d      = rx_s ? StIdle : StWaitHigh;
                    end
                end else if (end_evt) begin
                    stop_idx_d = 1'b1;
                end
            end
            StWaitHigh: begin
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= StIdle;
            baud_q       <= '0;
            div_cnt_q    <= '0;
            data_bits_q  <= '0;
            par_mode_q   <= '0;
            stop2_q      <= 1'b0;
            tick_cnt_q   <= '0;
            samp_a_q     <= 1'b0;
            samp_b_q     <= 1'b0;
            bit_idx_q    <= '0;
            stop_idx_q   <= 1'b0;
            data_q       <= '0;
            par_acc_q    <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            rx_byte_q    <= '0;
            done_q       <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            div_cnt_q    <= div_cnt_d;
            data_bits_q  <= data_bits_d;
            par_mode_q   <= par_mode_d;
            stop2_q      <= stop2_d;
            tick_cnt_q   <= tick_cnt_d;
            samp_a_q     <= samp_a_d;
            samp_b_q     <= samp_b_d;
            bit_idx_q    <= bit_idx_d;
            stop_idx_q   <= stop_idx_d;
            data_q       <= data_d;
            par_acc_q    <= par_acc_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            rx_byte_q    <= rx_byte_d;
            done_q       <= done_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign Rx_Byte    = rx_byte_q;
    assign Rx_Done    = done_q;
    assign Parity_Err = parity_err_q;
    assign Frame_Err  = frame_err_q;
    assign Busy       = (state_q != StIdle);

endmodule
